// File: rtl/maze_move_sequencer.sv
// Turns explorer move codes into timed turn/drive/settle motor phases and tracks heading, cell and exit.
// Optional build macro MOVE_SEQ_BOUNDS_CHECK_EN adds a grid-edge check on every drive.
module maze_move_sequencer #(
    parameter int GRID_W     = 9,
    parameter int GRID_H     = 9,
    parameter int START_POS  = 76,
    parameter int START_HEAD = 0,
    parameter int EXIT_POS   = 4,
    parameter int EXIT_HEAD  = 0,
    parameter int TURN_CYC   = 4,
    parameter int FWD_CYC    = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mv_valid,
    input  logic [2:0] mv_code,
    output logic       mv_ready,
    output logic [1:0] motor_l,
    output logic [1:0] motor_r,
    output logic       done,
    output logic [1:0] heading,
    output logic [6:0] pos,
    output logic [3:0] uturn_cnt,
    output logic       exit_flag,
    output logic       err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TURN   = 3'd1;
    localparam logic [2:0] S_DRIVE  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_EXIT   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [1:0] M_OFF = 2'b00;
    localparam logic [1:0] M_FWD = 2'b01;
    localparam logic [1:0] M_REV = 2'b10;

    generate
        if (GRID_W * GRID_H > 128) begin : g_grid_too_large
            $error("maze_move_sequencer: GRID_W*GRID_H must not exceed 128");
        end
    endgenerate

    logic [2:0] r_state, w_state_next;
    logic [7:0] r_cnt, w_cnt_next;
    logic       r_half, w_half_next;
    logic       r_dir, w_dir_next;
    logic       r_uturn, w_uturn_next;
    logic       r_exit_drv, w_exit_drv_next;
    logic [1:0] r_heading, w_head_next;
    logic [6:0] r_pos, w_pos_next;
    logic [3:0] r_uturn_cnt, w_uturn_cnt_next;
    logic       r_exit_flag, w_exit_flag_next;
    logic       r_err, w_err_next;
    logic       r_ready, r_done;
    logic [1:0] r_motor_l, r_motor_r, w_motor_l, w_motor_r;
    logic       w_enter_drive, w_oob;

`ifdef MOVE_SEQ_BOUNDS_CHECK_EN
    localparam logic [6:0] START_ROW = 7'(START_POS / GRID_W);
    localparam logic [6:0] START_COL = 7'(START_POS % GRID_W);
    logic [6:0] r_row, w_row_next;
    logic [6:0] r_col, w_col_next;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_half_next      = r_half;
        w_dir_next       = r_dir;
        w_uturn_next     = r_uturn;
        w_exit_drv_next  = r_exit_drv;
        w_head_next      = r_heading;
        w_pos_next       = r_pos;
        w_uturn_cnt_next = r_uturn_cnt;
        w_exit_flag_next = r_exit_flag;
        w_err_next       = r_err;
        w_enter_drive    = 1'b0;
        w_oob            = 1'b0;
`ifdef MOVE_SEQ_BOUNDS_CHECK_EN
        w_row_next       = r_row;
        w_col_next       = r_col;
`endif

        case (r_state)
            S_IDLE: begin
                if (mv_valid) begin
                    case (mv_code)
                        3'b001: w_enter_drive = 1'b1;
                        3'b010, 3'b011, 3'b100: begin
                            w_state_next = S_TURN;
                            w_cnt_next   = 8'(TURN_CYC - 1);
                            w_dir_next   = (mv_code != 3'b010);
                            w_uturn_next = (mv_code == 3'b100);
                            w_half_next  = 1'b0;
                        end
                        default: begin
                            w_state_next = S_DONE;
                            if (mv_code[2]) w_err_next = 1'b1;
                        end
                    endcase
                end
            end
            S_TURN: begin
                // A u-turn is two back-to-back quarter turns so the 8-bit counter never overflows.
                if (r_cnt != 8'd0) begin
                    w_cnt_next = r_cnt - 8'd1;
                end else if (r_uturn && !r_half) begin
                    w_half_next = 1'b1;
                    w_cnt_next  = 8'(TURN_CYC - 1);
                end else begin
                    if (r_uturn) begin
                        w_head_next = r_heading + 2'd2;
                        if (r_uturn_cnt != 4'hF) w_uturn_cnt_next = r_uturn_cnt + 4'd1;
                    end else if (r_dir) begin
                        w_head_next = r_heading + 2'd1;
                    end else begin
                        w_head_next = r_heading - 2'd1;
                    end
                    w_enter_drive = 1'b1;
                end
            end
            S_DRIVE: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_next = r_cnt - 8'd1;
                end else if (r_exit_drv) begin
                    w_state_next     = S_EXIT;
                    w_exit_flag_next = 1'b1;
                end else begin
                    w_state_next = S_SETTLE;
                    w_cnt_next   = 8'(SETTLE_CYC - 1);
                    case (r_heading)
                        2'd0:    w_pos_next = r_pos - 7'(GRID_W);
                        2'd1:    w_pos_next = r_pos + 7'd1;
                        2'd2:    w_pos_next = r_pos + 7'(GRID_W);
                        default: w_pos_next = r_pos - 7'd1;
                    endcase
`ifdef MOVE_SEQ_BOUNDS_CHECK_EN
                    case (r_heading)
                        2'd0:    w_row_next = r_row - 7'd1;
                        2'd1:    w_col_next = r_col + 7'd1;
                        2'd2:    w_row_next = r_row + 7'd1;
                        default: w_col_next = r_col - 7'd1;
                    endcase
`endif
                end
            end
            S_SETTLE: begin
                if (r_cnt != 8'd0) w_cnt_next = r_cnt - 8'd1;
                else               w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = r_state;
        endcase

        // Exit and bounds decisions use the post-turn heading, which is settled by now.
        if (w_enter_drive) begin
`ifdef MOVE_SEQ_BOUNDS_CHECK_EN
            w_oob = (w_head_next == 2'd0 && r_row == 7'd0) ||
                    (w_head_next == 2'd2 && r_row == 7'(GRID_H - 1)) ||
                    (w_head_next == 2'd3 && r_col == 7'd0) ||
                    (w_head_next == 2'd1 && r_col == 7'(GRID_W - 1));
`endif
            w_cnt_next = 8'(FWD_CYC - 1);
            if (r_pos == 7'(EXIT_POS) && w_head_next == 2'(EXIT_HEAD)) begin
                w_state_next    = S_DRIVE;
                w_exit_drv_next = 1'b1;
            end else if (w_oob) begin
                w_state_next = S_ERR;
                w_err_next   = 1'b1;
            end else begin
                w_state_next    = S_DRIVE;
                w_exit_drv_next = 1'b0;
            end
        end

        w_motor_l = M_OFF;
        w_motor_r = M_OFF;
        if (w_state_next == S_TURN) begin
            w_motor_l = w_dir_next ? M_FWD : M_REV;
            w_motor_r = w_dir_next ? M_REV : M_FWD;
        end else if (w_state_next == S_DRIVE) begin
            w_motor_l = M_FWD;
            w_motor_r = M_FWD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_half      <= 1'b0;
            r_dir       <= 1'b0;
            r_uturn     <= 1'b0;
            r_exit_drv  <= 1'b0;
            r_heading   <= 2'(START_HEAD);
            r_pos       <= 7'(START_POS);
            r_uturn_cnt <= 4'd0;
            r_exit_flag <= 1'b0;
            r_err       <= 1'b0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_motor_l   <= M_OFF;
            r_motor_r   <= M_OFF;
`ifdef MOVE_SEQ_BOUNDS_CHECK_EN
            r_row       <= START_ROW;
            r_col       <= START_COL;
`endif
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_half      <= w_half_next;
            r_dir       <= w_dir_next;
            r_uturn     <= w_uturn_next;
            r_exit_drv  <= w_exit_drv_next;
            r_heading   <= w_head_next;
            r_pos       <= w_pos_next;
            r_uturn_cnt <= w_uturn_cnt_next;
            r_exit_flag <= w_exit_flag_next;
            r_err       <= w_err_next;
            r_ready     <= (w_state_next == S_IDLE);
            r_done      <= (r_state == S_DONE);
            r_motor_l   <= w_motor_l;
            r_motor_r   <= w_motor_r;
`ifdef MOVE_SEQ_BOUNDS_CHECK_EN
            r_row       <= w_row_next;
            r_col       <= w_col_next;
`endif
        end
    end

    assign mv_ready  = r_ready;
    assign motor_l   = r_motor_l;
    assign motor_r   = r_motor_r;
    assign done      = r_done;
    assign heading   = r_heading;
    assign pos       = r_pos;
    assign uturn_cnt = r_uturn_cnt;
    assign exit_flag = r_exit_flag;
    assign err       = r_err;

endmodule

// File: tb/tb_maze_move_sequencer.sv
// Directed bench: main sequencer (start 76), exit-cell sequencer (start 4), corner sequencer (start 0).
module tb_maze_move_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mv_valid = 1'b0;
    logic [2:0] mv_code = 3'd0;

    logic       a_ready, a_done, a_exit, a_err;
    logic [1:0] a_ml, a_mr, a_head;
    logic [6:0] a_pos;
    logic [3:0] a_ut;
    logic       b_ready, b_done, b_exit, b_err;
    logic [1:0] b_ml, b_mr, b_head;
    logic [6:0] b_pos;
    logic [3:0] b_ut;
    logic       c_ready, c_done, c_exit, c_err;
    logic [1:0] c_ml, c_mr, c_head;
    logic [6:0] c_pos;
    logic [3:0] c_ut;

    int checks = 0;
    int errors = 0;
    int b_done_cnt = 0;

    always #5 clk = ~clk;

    maze_move_sequencer u_a (
        .clk(clk), .rst(rst), .mv_valid(mv_valid), .mv_code(mv_code), .mv_ready(a_ready),
        .motor_l(a_ml), .motor_r(a_mr), .done(a_done), .heading(a_head), .pos(a_pos),
        .uturn_cnt(a_ut), .exit_flag(a_exit), .err(a_err)
    );

    maze_move_sequencer #(.START_POS(4)) u_b (
        .clk(clk), .rst(rst), .mv_valid(mv_valid), .mv_code(mv_code), .mv_ready(b_ready),
        .motor_l(b_ml), .motor_r(b_mr), .done(b_done), .heading(b_head), .pos(b_pos),
        .uturn_cnt(b_ut), .exit_flag(b_exit), .err(b_err)
    );

    maze_move_sequencer #(.START_POS(0)) u_c (
        .clk(clk), .rst(rst), .mv_valid(mv_valid), .mv_code(mv_code), .mv_ready(c_ready),
        .motor_l(c_ml), .motor_r(c_mr), .done(c_done), .heading(c_head), .pos(c_pos),
        .uturn_cnt(c_ut), .exit_flag(c_exit), .err(c_err)
    );

    always @(negedge clk) if (b_done) b_done_cnt++;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a code for exactly one edge; returns 1 ns after the acceptance edge.
    task automatic accept(input logic [2:0] code);
        mv_valid = 1'b1;
        mv_code  = code;
        step();
        mv_valid = 1'b0;
        mv_code  = 3'd0;
    endtask

    task automatic wait_done(input string tag, input int exp);
        int k = 0;
        while (!a_done && k < 200) begin
            step();
            k++;
        end
        check(tag, 8'(k), 8'(exp));
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        step();
        check("rst_pos", 8'(a_pos), 8'd76);
        check("rst_head", 8'(a_head), 8'd0);
        check("rst_ready", 8'(a_ready), 8'd1);
        check("rst_motor_l", 8'(a_ml), 8'd0);
        check("rst_motor_r", 8'(a_mr), 8'd0);
        check("rst_done", 8'(a_done), 8'd0);
        check("rst_uturn", 8'(a_ut), 8'd0);
        check("rst_exit", 8'(a_exit), 8'd0);
        check("rst_err", 8'(a_err), 8'd0);
        check("rst_b_pos", 8'(b_pos), 8'd4);
        check("rst_c_pos", 8'(c_pos), 8'd0);

        accept(3'b001);
        check("fwd_ready_low", 8'(a_ready), 8'd0);
        check("fwd_motor_l", 8'(a_ml), 8'b01);
        check("fwd_motor_r", 8'(a_mr), 8'b01);
        wait_done("fwd_latency", 11);
        check("fwd_pos", 8'(a_pos), 8'd67);
        check("fwd_head", 8'(a_head), 8'd0);
        check("fwd_motors_off", 8'({a_ml, a_mr}), 8'd0);
        check("exit_flag", 8'(b_exit), 8'd1);
        check("exit_pos", 8'(b_pos), 8'd4);
        check("exit_ready", 8'(b_ready), 8'd0);
        check("exit_motors", 8'({b_ml, b_mr}), 8'd0);
        check("exit_no_done", 8'(b_done_cnt), 8'd0);
`ifdef MOVE_SEQ_BOUNDS_CHECK_EN
        check("oob_err", 8'(c_err), 8'd1);
        check("oob_pos", 8'(c_pos), 8'd0);
        check("oob_ready", 8'(c_ready), 8'd0);
        check("oob_motors", 8'({c_ml, c_mr}), 8'd0);
`else
        check("wrap_pos", 8'(c_pos), 8'd119);
        check("wrap_err", 8'(c_err), 8'd0);
`endif

        accept(3'b010);
        check("left_motor_l", 8'(a_ml), 8'b10);
        check("left_motor_r", 8'(a_mr), 8'b01);
        wait_done("left_latency", 15);
        check("left_head", 8'(a_head), 8'd3);
        check("left_pos", 8'(a_pos), 8'd66);

        accept(3'b100);
        check("uturn_motor_l", 8'(a_ml), 8'b01);
        check("uturn_motor_r", 8'(a_mr), 8'b10);
        wait_done("uturn_latency", 19);
        check("uturn_head", 8'(a_head), 8'd1);
        check("uturn_pos", 8'(a_pos), 8'd67);
        check("uturn_cnt", 8'(a_ut), 8'd1);

        accept(3'b110);
        wait_done("illegal_latency", 1);
        check("illegal_err", 8'(a_err), 8'd1);
        check("illegal_pos", 8'(a_pos), 8'd67);
        check("illegal_head", 8'(a_head), 8'd1);

        accept(3'b001);
        step(); step();
        check("mid_drive_motor", 8'(a_ml), 8'b01);
        rst = 1'b1;
        step();
        check("mid_rst_pos", 8'(a_pos), 8'd76);
        check("mid_rst_head", 8'(a_head), 8'd0);
        check("mid_rst_ready", 8'(a_ready), 8'd1);
        check("mid_rst_motors", 8'({a_ml, a_mr}), 8'd0);
        check("mid_rst_uturn", 8'(a_ut), 8'd0);
        check("mid_rst_err", 8'(a_err), 8'd0);
        check("mid_rst_done", 8'(a_done), 8'd0);
        check("mid_rst_b_exit", 8'(b_exit), 8'd0);
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
